aes_byte_io: RTL and testbench

Byte-serial I/O front/back end for the team's combinational AES-128 encrypt core, which takes a 128-bit plaintext and key and produces a 128-bit ciphertext. The block assembles 16 key bytes and 16 plaintext bytes from an 8-bit pin bus into 128-bit registers and presents them to the core. After a programmable wait it captures the core result and streams the 16 result bytes back out with a valid/ready handshake. It sits directly upstream and downstream of the core inside the top wrapper.

---
 rtl/aes_byte_io_if.sv | 37 +++
 rtl/aes_byte_io.sv | 122 ++++++++++++
 tb/tb_aes_byte_io.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_byte_io_if.sv
// Pin-side byte bus of aes_byte_io: load bytes and start in, result bytes and status out.
// The master modport is the host that loads and drains; the slave modport is aes_byte_io.
interface aes_byte_io_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       sel_key;
  logic       start;
  logic [7:0] byte_out;
  logic       byte_out_valid;
  logic       byte_out_ready;
  logic       busy;
  logic       done;

  modport master (
    output byte_in,
    output byte_valid,
    output sel_key,
    output start,
    output byte_out_ready,
    input  byte_out,
    input  byte_out_valid,
    input  busy,
    input  done
  );

  modport slave (
    input  byte_in,
    input  byte_valid,
    input  sel_key,
    input  start,
    input  byte_out_ready,
    output byte_out,
    output byte_out_valid,
    output busy,
    output done
  );
endinterface

// File: rtl/aes_byte_io.sv
// Byte-serial load/unload wrapper for the combinational AES-128 encrypt core.
// Define AES_KEY_SINGLE_USE_EN to clear the key after every block (fresh key per block).
module aes_byte_io #(
  parameter int BLOCK_BYTES = 16,
  parameter int LAT_CYCLES  = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  aes_byte_io_if.slave bus,
  output logic [127:0] key_out,
  output logic [127:0] text_out,
  input  logic [127:0] core_result
);

  // state | meaning
  // IDLE  | accept key/plaintext bytes; launch once both registers hold 16 bytes
  // WAIT  | core inputs stable; count down core latency, then capture result
  // SHIFT | present result MSB byte first, advance on each accepted byte
  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SHIFT
  } state_t;

  localparam logic [4:0] FULL_CNT  = 5'(BLOCK_BYTES);
  localparam logic [3:0] LAST_OUT  = 4'(BLOCK_BYTES - 1);
  localparam logic [3:0] WAIT_LOAD = 4'(LAT_CYCLES - 1);

  state_t       state;
  logic [127:0] result_reg;
  logic [4:0]   key_cnt;
  logic [4:0]   text_cnt;
  logic [3:0]   out_cnt;
  logic [3:0]   wait_cnt;
  logic         byte_out_valid_r;
  logic         busy_r;
  logic         done_r;
  logic         key_full;
  logic         text_full;
  logic         accept;

  assign key_full  = (key_cnt == FULL_CNT);
  assign text_full = (text_cnt == FULL_CNT);
  assign accept    = byte_out_valid_r && bus.byte_out_ready;

  assign bus.byte_out       = result_reg[127:120];
  assign bus.byte_out_valid = byte_out_valid_r;
  assign bus.busy           = busy_r;
  assign bus.done           = done_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      key_out          <= '0;
      text_out         <= '0;
      result_reg       <= '0;
      key_cnt          <= '0;
      text_cnt         <= '0;
      out_cnt          <= '0;
      wait_cnt         <= '0;
      byte_out_valid_r <= 1'b0;
      busy_r           <= 1'b0;
      done_r           <= 1'b0;
    end else if (ena) begin
      done_r <= 1'b0;
      unique case (state)
        S_IDLE: begin
          // Launch wins over a byte arriving in the same cycle.
          if (bus.start && key_full && text_full) begin
            state    <= S_WAIT;
            busy_r   <= 1'b1;
            wait_cnt <= WAIT_LOAD;
          end else if (bus.byte_valid) begin
            if (bus.sel_key) begin
              if (!key_full) begin
                key_out <= {key_out[119:0], bus.byte_in};
                key_cnt <= key_cnt + 5'd1;
              end
            end else if (!text_full) begin
              text_out <= {text_out[119:0], bus.byte_in};
              text_cnt <= text_cnt + 5'd1;
            end
          end
        end

        S_WAIT: begin
          if (wait_cnt == 4'd0) begin
            result_reg       <= core_result;
            out_cnt          <= '0;
            byte_out_valid_r <= 1'b1;
            state            <= S_SHIFT;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end

        S_SHIFT: begin
          if (accept) begin
            result_reg <= {result_reg[119:0], 8'h00};
            if (out_cnt == LAST_OUT) begin
              state            <= S_IDLE;
              byte_out_valid_r <= 1'b0;
              busy_r           <= 1'b0;
              done_r           <= 1'b1;
              text_cnt         <= '0;
`ifdef AES_KEY_SINGLE_USE_EN
              key_out          <= '0;
              key_cnt          <= '0;
`endif
            end else begin
              out_cnt <= out_cnt + 4'd1;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_byte_io.sv
// Directed + randomized bench for aes_byte_io with a stand-in core and a byte-queue model.
// Two instances: LAT_CYCLES=1 for the main traffic, LAT_CYCLES=3 for the wait/enable checks.
`timescale 1ns/1ps
module tb_aes_byte_io;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ena;
  logic [127:0] key_out1, text_out1, core1;
  logic [127:0] key_out3, text_out3, core3;
  int           n_vec = 0;
  int           n_err = 0;
  logic [7:0]   mkey[$];
  logic [7:0]   mtext[$];

  aes_byte_io_if bus1();
  aes_byte_io_if bus3();

  assign bus3.byte_in        = bus1.byte_in;
  assign bus3.byte_valid     = bus1.byte_valid;
  assign bus3.sel_key        = bus1.sel_key;
  assign bus3.start          = bus1.start;
  assign bus3.byte_out_ready = bus1.byte_out_ready;

  aes_byte_io #(.BLOCK_BYTES(16), .LAT_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .bus(bus1),
    .key_out(key_out1), .text_out(text_out1), .core_result(core1)
  );

  aes_byte_io #(.BLOCK_BYTES(16), .LAT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .bus(bus3),
    .key_out(key_out3), .text_out(text_out3), .core_result(core3)
  );

  always #5 clk = ~clk;

  // Stand-in core: the FIPS-197 vector, otherwise an arbitrary mix of key and text.
  function automatic logic [127:0] core_fn(input logic [127:0] k, input logic [127:0] t);
    if (k == FIPS_KEY && t == FIPS_PT) return FIPS_CT;
    return k ^ {t[63:0], t[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  endfunction

  assign core1 = core_fn(key_out1, text_out1);

  // Register image implied by the bytes accepted so far: first byte most significant.
  function automatic logic [127:0] model_reg(input bit sel);
    logic [127:0] v;
    v = '0;
    if (sel) foreach (mkey[i])  v = (v << 8) | 128'(mkey[i]);
    else     foreach (mtext[i]) v = (v << 8) | 128'(mtext[i]);
    return v;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_byte(input bit sel, input logic [7:0] b, input bit en);
    bus1.sel_key    = sel;
    bus1.byte_in    = b;
    bus1.byte_valid = 1'b1;
    ena             = en;
    tick();
    bus1.byte_valid = 1'b0;
    ena             = 1'b1;
    if (en) begin
      if (sel) begin
        if (mkey.size() < 16) mkey.push_back(b);
      end else begin
        if (mtext.size() < 16) mtext.push_back(b);
      end
    end
  endtask

  task automatic load_block(input bit sel, input logic [127:0] blk, input int n);
    for (int i = 0; i < n; i++) load_byte(sel, blk[127-8*i -: 8], 1'b1);
  endtask

  task automatic ensure_fips_key();
    if (mkey.size() == 0) load_block(1'b1, FIPS_KEY, 16);
  endtask

  task automatic try_start(input string tag);
    bus1.start = 1'b1;
    tick();
    check({tag, "_busy0"}, 128'(bus1.busy), 128'(0));
    tick();
    check({tag, "_busy1"}, 128'(bus1.busy), 128'(0));
    bus1.start = 1'b0;
  endtask

  task automatic apply_reset();
    bus1.start = 1'b0;
    bus1.byte_valid = 1'b0;
    bus1.byte_out_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    mkey.delete();
    mtext.delete();
  endtask

  // mode 0: ready held 1; mode 1: ready pattern 1,0,0,1; mode 2: random ready.
  task automatic run_op(input int mode, input string tag);
    logic [127:0] k, t, exp;
    int   idx, cyc;
    logic rdy;
    k = model_reg(1'b1);
    t = model_reg(1'b0);
    exp = core_fn(k, t);
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    check({tag, "_busy_launch"}, 128'(bus1.busy), 128'(1));
    check({tag, "_key_launch"}, key_out1, k);
    check({tag, "_text_launch"}, text_out1, t);
    idx = 0;
    cyc = 0;
    while (idx < 16 && cyc < 200) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      bus1.byte_out_ready = rdy;
      if (bus1.byte_out_valid) begin
        check($sformatf("%s_byte%0d", tag, idx), 128'(bus1.byte_out), 128'(exp[127-8*idx -: 8]));
        check({tag, "_done_early"}, 128'(bus1.done), 128'(0));
        if (rdy) idx++;
      end
      tick();
      cyc++;
    end
    check({tag, "_all_bytes"}, 128'(idx), 128'(16));
    if (mode == 0) check({tag, "_cycles"}, 128'(cyc), 128'(17));
    check({tag, "_done"}, 128'(bus1.done), 128'(1));
    check({tag, "_busy_end"}, 128'(bus1.busy), 128'(0));
    check({tag, "_valid_end"}, 128'(bus1.byte_out_valid), 128'(0));
    mtext.delete();
`ifdef AES_KEY_SINGLE_USE_EN
    mkey.delete();
`endif
    check({tag, "_key_after"}, key_out1, model_reg(1'b1));
    tick();
    check({tag, "_done_pulse"}, 128'(bus1.done), 128'(0));
    check({tag, "_text_held"}, text_out1, t);
    bus1.byte_out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] v1, v3, exp1;
    logic [127:0] pt;
    rst_n = 1'b0;
    ena = 1'b1;
    bus1.byte_in = 8'h00;
    bus1.byte_valid = 1'b0;
    bus1.sel_key = 1'b0;
    bus1.start = 1'b0;
    bus1.byte_out_ready = 1'b0;
    core3 = '0;
    #3;
    check("rst_valid", 128'(bus1.byte_out_valid), 128'(0));
    check("rst_busy", 128'(bus1.busy), 128'(0));
    check("rst_done", 128'(bus1.done), 128'(0));
    check("rst_byte_out", 128'(bus1.byte_out), 128'(0));
    check("rst_key", key_out1, '0);
    check("rst_text", text_out1, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // FIPS-197 vector with ready held high
    load_block(1'b1, FIPS_KEY, 16);
    load_block(1'b0, FIPS_PT, 16);
    check("t1_key", key_out1, FIPS_KEY);
    check("t1_text", text_out1, FIPS_PT);
    run_op(0, "t1");

    // key reuse: only plaintext reloaded
    load_block(1'b0, FIPS_PT, 16);
    if (mkey.size() < 16) begin
      try_start("t2_nokey");
      load_block(1'b1, FIPS_KEY, 16);
    end
    run_op(0, "t2");

    // premature start and overflow bytes
    ensure_fips_key();
    load_block(1'b0, FIPS_PT, 15);
    try_start("t3_premature");
    load_byte(1'b0, 8'hff, 1'b1);
    load_byte(1'b0, 8'haa, 1'b1);
    load_byte(1'b1, 8'h77, 1'b1);
    check("t3_text_drop", text_out1, FIPS_PT);
    check("t3_key_drop", key_out1, FIPS_KEY);
    run_op(0, "t3");

    // backpressure with random plaintext
    ensure_fips_key();
    load_block(1'b0, rand128(), 16);
    run_op(1, "t4");

    // reset during SHIFT after 5 accepted bytes
    ensure_fips_key();
    load_block(1'b0, rand128(), 16);
    exp1 = core_fn(model_reg(1'b1), model_reg(1'b0));
    bus1.byte_out_ready = 1'b1;
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) tick();
    check("t5_pre_rst_byte", 128'(bus1.byte_out), 128'(exp1[127-40 -: 8]));
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_valid", 128'(bus1.byte_out_valid), 128'(0));
    check("t5_busy", 128'(bus1.busy), 128'(0));
    check("t5_key", key_out1, '0);
    check("t5_text", text_out1, '0);
    check("t5_done", 128'(bus1.done), 128'(0));
    mkey.delete();
    mtext.delete();
    tick();
    rst_n = 1'b1;
    bus1.byte_out_ready = 1'b0;
    tick();
    check("t5_done_after", 128'(bus1.done), 128'(0));
    try_start("t5_start_after");

    // LAT_CYCLES=3 instance: enable frozen for 10 cycles inside WAIT
    load_block(1'b1, FIPS_KEY, 16);
    load_block(1'b0, rand128(), 16);
    exp1 = core_fn(model_reg(1'b1), model_reg(1'b0));
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    check("t6_busy3", 128'(bus3.busy), 128'(1));
    check("t6_valid3_e0", 128'(bus3.byte_out_valid), 128'(0));
    core3 = rand128();
    tick();
    check("t6_valid3_e1", 128'(bus3.byte_out_valid), 128'(0));
    ena = 1'b0;
    bus1.byte_out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      core3 = rand128();
      tick();
      check($sformatf("t6_frz_valid3_%0d", i), 128'(bus3.byte_out_valid), 128'(0));
      check($sformatf("t6_frz_busy3_%0d", i), 128'(bus3.busy), 128'(1));
      check($sformatf("t6_frz_byte1_%0d", i), 128'(bus1.byte_out), 128'(exp1[127:120]));
      check($sformatf("t6_frz_valid1_%0d", i), 128'(bus1.byte_out_valid), 128'(1));
    end
    ena = 1'b1;
    core3 = rand128();
    tick();
    check("t6_valid3_e2", 128'(bus3.byte_out_valid), 128'(0));
    v3 = rand128();
    core3 = v3;
    tick();
    check("t6_valid3_e3", 128'(bus3.byte_out_valid), 128'(1));
    v1 = ~v3;
    core3 = v1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t6_byte3_%0d", i), 128'(bus3.byte_out), 128'(v3[127-8*i -: 8]));
      tick();
    end
    check("t6_done3", 128'(bus3.done), 128'(1));
    apply_reset();

    // randomized loading, enable gaps and ready
    for (int it = 0; it < 4; it++) begin
      for (int j = 0; j < 40; j++) begin
        case ($urandom_range(0, 5))
          0: begin
            bus1.sel_key = 1'($urandom_range(0, 1));
            bus1.byte_in = 8'($urandom);
            tick();
          end
          1:       load_byte(1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
          default: load_byte(1'($urandom_range(0, 1)), 8'($urandom), 1'b1);
        endcase
      end
      while (mkey.size() < 16) load_byte(1'b1, 8'($urandom), 1'b1);
      while (mtext.size() < 16) load_byte(1'b0, 8'($urandom), 1'b1);
      pt = model_reg(1'b0);
      check($sformatf("r%0d_key", it), key_out1, model_reg(1'b1));
      check($sformatf("r%0d_text", it), text_out1, pt);
      run_op(2, $sformatf("r%0d", it));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
